// File: rtl/term_pkg.sv
// +------------------------------------------------------------------+
// | term_pkg : key codes, scancodes, FSM state and cursor events     |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
`default_nettype none

package term_pkg;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] ESC   = 8'h1B;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] TILDE = 8'h7E;

  localparam logic [7:0] LEFT  = 8'h6B;
  localparam logic [7:0] RIGHT = 8'h74;
  localparam logic [7:0] UP    = 8'h75;
  localparam logic [7:0] DOWN  = 8'h72;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    EV_NONE  = 3'd0,
    EV_PRINT = 3'd1,
    EV_CR    = 3'd2,
    EV_BS    = 3'd3,
    EV_LEFT  = 3'd4,
    EV_RIGHT = 3'd5,
    EV_UP    = 3'd6,
    EV_DOWN  = 3'd7
  } cur_ev_e;

  // A valid ASCII strobe always shadows a simultaneous scancode.
  function automatic cur_ev_e decode_ev(input logic       a_vld,
                                        input logic [7:0] a,
                                        input logic       s_vld,
                                        input logic [7:0] s);
    cur_ev_e ev;
    ev = EV_NONE;
    if (a_vld) begin
      if (a >= SPACE && a <= TILDE) ev = EV_PRINT;
      else if (a == CR)             ev = EV_CR;
      else if (a == BS)             ev = EV_BS;
    end else if (s_vld) begin
      case (s)
        LEFT:    ev = EV_LEFT;
        RIGHT:   ev = EV_RIGHT;
        UP:      ev = EV_UP;
        DOWN:    ev = EV_DOWN;
        default: ev = EV_NONE;
      endcase
    end
    return ev;
  endfunction

endpackage

`default_nettype wire

// File: rtl/term_cursor_step.sv
// +------------------------------------------------------------------+
// | term_cursor_step : next cursor position and write flag per event |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
`default_nettype none

module term_cursor_step
  import term_pkg::*;
#(
  parameter  int COLS  = 80,
  parameter  int ROWS  = 25,
  localparam int COL_W = $clog2(COLS),
  localparam int ROW_W = $clog2(ROWS)
) (
  input  logic [COL_W-1:0] col_i,
  input  logic [ROW_W-1:0] row_i,
  input  cur_ev_e          ev_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             wr_o
);

  logic             w_col_first;
  logic             w_col_last;
  logic             w_row_first;
  logic             w_row_last;
  logic [ROW_W-1:0] w_row_down;

  assign w_col_first = (col_i == '0);
  assign w_col_last  = (col_i == COL_W'(COLS - 1));
  assign w_row_first = (row_i == '0);
  assign w_row_last  = (row_i == ROW_W'(ROWS - 1));
  // ROWS need not be a power of two, so the wrap is explicit.
  assign w_row_down  = w_row_last ? '0 : row_i + ROW_W'(1);

  always_comb begin
    col_o = col_i;
    row_o = row_i;
    wr_o  = 1'b0;
    case (ev_i)
      EV_PRINT: begin
        wr_o = 1'b1;
        if (w_col_last) begin
          col_o = '0;
          row_o = w_row_down;
        end else begin
          col_o = col_i + COL_W'(1);
        end
      end
      EV_CR: begin
        col_o = '0;
        row_o = w_row_down;
      end
      EV_BS: begin
        if (!w_col_first) begin
          col_o = col_i - COL_W'(1);
          wr_o  = 1'b1;
        end else if (!w_row_first) begin
          col_o = COL_W'(COLS - 1);
          row_o = row_i - ROW_W'(1);
          wr_o  = 1'b1;
        end
      end
      EV_LEFT:  if (!w_col_first) col_o = col_i - COL_W'(1);
      EV_RIGHT: if (!w_col_last)  col_o = col_i + COL_W'(1);
      EV_UP:    if (!w_row_first) row_o = row_i - ROW_W'(1);
      EV_DOWN:  if (!w_row_last)  row_o = row_i + ROW_W'(1);
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/term_input_ctrl.sv
// +------------------------------------------------------------------+
// | term_input_ctrl : keyboard-to-text-buffer writer with cursor     |
// | Optional screen clear via macro TERM_INPUT_CTRL_CLEAR_EN         |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
`default_nettype none

module term_input_ctrl
  import term_pkg::*;
#(
  parameter  int COLS  = 80,
  parameter  int ROWS  = 25,
  localparam int COL_W = $clog2(COLS),
  localparam int ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ascii_vld,
  input  logic [7:0]       ascii,
  input  logic             scan_vld,
  input  logic [7:0]       scan,
  input  logic             clear_req,
  output logic             wr_en,
  output logic [COL_W-1:0] wr_col,
  output logic [ROW_W-1:0] wr_row,
  output logic [7:0]       wr_char,
  output logic [COL_W-1:0] cur_col,
  output logic [ROW_W-1:0] cur_row,
  output logic             busy
);

  logic             wr_en_q,   wr_en_d;
  logic [COL_W-1:0] wr_col_q,  wr_col_d;
  logic [ROW_W-1:0] wr_row_q,  wr_row_d;
  logic [7:0]       wr_char_q, wr_char_d;
  logic [COL_W-1:0] cur_col_q, cur_col_d;
  logic [ROW_W-1:0] cur_row_q, cur_row_d;

  cur_ev_e          w_ev;
  logic [COL_W-1:0] w_step_col;
  logic [ROW_W-1:0] w_step_row;
  logic             w_step_wr;
  logic             w_take_ev;

  assign w_ev = decode_ev(ascii_vld, ascii, scan_vld, scan);

  term_cursor_step #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_step (
    .col_i (cur_col_q),
    .row_i (cur_row_q),
    .ev_i  (w_ev),
    .col_o (w_step_col),
    .row_o (w_step_row),
    .wr_o  (w_step_wr)
  );

`ifdef TERM_INPUT_CTRL_CLEAR_EN
  state_e           state_q,  state_d;
  logic             busy_q,   busy_d;
  logic [COL_W-1:0] sw_col_q, sw_col_d;
  logic [ROW_W-1:0] sw_row_q, sw_row_d;
  logic             w_clr_req;
  logic             w_accept;
  logic             w_sw_last;

  assign w_clr_req = clear_req | (ascii_vld & (ascii == ESC));
  // busy stays high through the final sweep write, so idle alone is not enough.
  assign w_accept  = (state_q == IDLE) & ~busy_q;
  assign w_take_ev = w_accept & ~w_clr_req;
  assign w_sw_last = (sw_col_q == COL_W'(COLS - 1)) & (sw_row_q == ROW_W'(ROWS - 1));
  assign busy      = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      sw_col_q <= '0;
      sw_row_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      sw_col_q <= sw_col_d;
      sw_row_q <= sw_row_d;
    end
  end
`else
  logic unused_clear_req;

  assign unused_clear_req = clear_req;
  assign w_take_ev        = 1'b1;
  assign busy             = 1'b0;
`endif

  always_comb begin
    wr_en_d   = 1'b0;
    wr_col_d  = wr_col_q;
    wr_row_d  = wr_row_q;
    wr_char_d = wr_char_q;
    cur_col_d = cur_col_q;
    cur_row_d = cur_row_q;

    if (w_take_ev) begin
      cur_col_d = w_step_col;
      cur_row_d = w_step_row;
      if (w_step_wr) begin
        // Printables land at the old cell; backspace blanks the new one.
        wr_en_d   = 1'b1;
        wr_col_d  = (w_ev == EV_PRINT) ? cur_col_q : w_step_col;
        wr_row_d  = (w_ev == EV_PRINT) ? cur_row_q : w_step_row;
        wr_char_d = (w_ev == EV_PRINT) ? ascii     : SPACE;
      end
    end

`ifdef TERM_INPUT_CTRL_CLEAR_EN
    state_d  = state_q;
    busy_d   = 1'b0;
    sw_col_d = sw_col_q;
    sw_row_d = sw_row_q;
    case (state_q)
      IDLE: begin
        if (w_accept && w_clr_req) begin
          state_d   = CLEAR;
          busy_d    = 1'b1;
          wr_en_d   = 1'b1;
          wr_col_d  = '0;
          wr_row_d  = '0;
          wr_char_d = SPACE;
          sw_col_d  = COL_W'(1);
          sw_row_d  = '0;
        end
      end
      CLEAR: begin
        busy_d    = 1'b1;
        wr_en_d   = 1'b1;
        wr_col_d  = sw_col_q;
        wr_row_d  = sw_row_q;
        wr_char_d = SPACE;
        if (sw_col_q == COL_W'(COLS - 1)) begin
          sw_col_d = '0;
          sw_row_d = sw_row_q + ROW_W'(1);
        end else begin
          sw_col_d = sw_col_q + COL_W'(1);
        end
        if (w_sw_last) begin
          state_d   = IDLE;
          cur_col_d = '0;
          cur_row_d = '0;
        end
      end
    endcase
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_col_q  <= '0;
      wr_row_q  <= '0;
      wr_char_q <= '0;
      cur_col_q <= '0;
      cur_row_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_col_q  <= wr_col_d;
      wr_row_q  <= wr_row_d;
      wr_char_q <= wr_char_d;
      cur_col_q <= cur_col_d;
      cur_row_q <= cur_row_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_col  = wr_col_q;
  assign wr_row  = wr_row_q;
  assign wr_char = wr_char_q;
  assign cur_col = cur_col_q;
  assign cur_row = cur_row_q;

endmodule

`default_nettype wire

// File: tb/tb_term_input_ctrl.sv
// +------------------------------------------------------------------+
// | tb_term_input_ctrl : model-checked bench for term_input_ctrl     |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_term_input_ctrl;

  localparam int COLS = 16;
  localparam int ROWS = 4;
  localparam int N    = COLS * ROWS;
  localparam int CW   = 4;
  localparam int RW   = 2;
`ifdef TERM_INPUT_CTRL_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ascii_vld = 1'b0;
  logic [7:0]    ascii = 8'h00;
  logic          scan_vld = 1'b0;
  logic [7:0]    scan = 8'h00;
  logic          clear_req = 1'b0;
  logic          wr_en;
  logic [CW-1:0] wr_col;
  logic [RW-1:0] wr_row;
  logic [7:0]    wr_char;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          busy;

  int n_pass = 0;
  int n_tot  = 0;
  bit cmp_en = 1'b0;

  term_input_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk       (clk),
    .rst       (rst),
    .ascii_vld (ascii_vld),
    .ascii     (ascii),
    .scan_vld  (scan_vld),
    .scan      (scan),
    .clear_req (clear_req),
    .wr_en     (wr_en),
    .wr_col    (wr_col),
    .wr_row    (wr_row),
    .wr_char   (wr_char),
    .cur_col   (cur_col),
    .cur_row   (cur_row),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: cursor as (col,row) integers, sweep as a linear cell index.
  int         m_col, m_row, m_wcol, m_wrow, m_sweep, m_idx;
  logic [7:0] m_ch;
  bit         m_wr, m_busy, m_was_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_col = 0; m_row = 0; m_wcol = 0; m_wrow = 0; m_ch = 8'h00;
      m_wr = 1'b0; m_busy = 1'b0; m_sweep = 0;
    end else begin
      m_was_busy = m_busy;
      m_wr   = 1'b0;
      m_busy = 1'b0;
      if (m_was_busy) begin
        if (m_sweep != 0) begin
          m_wr = 1'b1; m_busy = 1'b1; m_ch = 8'h20;
          m_wcol = m_sweep % COLS; m_wrow = m_sweep / COLS;
          m_sweep++;
          if (m_sweep == N) begin
            m_sweep = 0; m_col = 0; m_row = 0;
          end
        end
      end else if (CLR_EN && (clear_req || (ascii_vld && ascii == 8'h1B))) begin
        m_wr = 1'b1; m_busy = 1'b1; m_ch = 8'h20;
        m_wcol = 0; m_wrow = 0; m_sweep = 1;
      end else if (ascii_vld) begin
        if (ascii >= 8'h20 && ascii <= 8'h7E) begin
          m_wr = 1'b1; m_ch = ascii; m_wcol = m_col; m_wrow = m_row;
          m_idx = (m_row * COLS + m_col + 1) % N;
          m_col = m_idx % COLS; m_row = m_idx / COLS;
        end else if (ascii == 8'h0D) begin
          m_col = 0; m_row = (m_row + 1) % ROWS;
        end else if (ascii == 8'h08) begin
          m_idx = m_row * COLS + m_col;
          if (m_idx > 0) begin
            m_idx--;
            m_col = m_idx % COLS; m_row = m_idx / COLS;
            m_wr = 1'b1; m_ch = 8'h20; m_wcol = m_col; m_wrow = m_row;
          end
        end
      end else if (scan_vld) begin
        case (scan)
          8'h6B: if (m_col > 0)        m_col--;
          8'h74: if (m_col < COLS - 1) m_col++;
          8'h75: if (m_row > 0)        m_row--;
          8'h72: if (m_row < ROWS - 1) m_row++;
          default: ;
        endcase
      end
    end
  end

  logic [21:0] act_v, exp_v;

  always @(negedge clk) begin
    if (cmp_en) begin
      act_v = {wr_en, wr_en ? {wr_col, wr_row, wr_char} : 14'd0, cur_col, cur_row, busy};
      exp_v = {m_wr, m_wr ? {CW'(m_wcol), RW'(m_wrow), m_ch} : 14'd0,
               CW'(m_col), RW'(m_row), m_busy};
      chk("cycle", 32'(act_v), 32'(exp_v));
    end
  end

  task automatic send(input logic av, input logic [7:0] a, input logic sv,
                      input logic [7:0] s, input logic cr);
    ascii_vld = av; ascii = a; scan_vld = sv; scan = s; clear_req = cr;
    @(negedge clk);
    ascii_vld = 1'b0; scan_vld = 1'b0; clear_req = 1'b0;
  endtask

  task automatic mv(input logic [7:0] sc, input int n);
    for (int i = 0; i < n; i++) send(1'b0, 8'h00, 1'b1, sc, 1'b0);
  endtask

  int cnt;
  bit sweep_ok;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_pos", 32'({wr_col, wr_row, wr_char}), 0);
    chk("rst_cursor", 32'({cur_col, cur_row}), 0);
    chk("rst_busy", 32'(busy), 0);

    send(1'b1, 8'h41, 1'b0, 8'h00, 1'b0);
    chk("first_write", 32'({wr_en, wr_col, wr_row, wr_char}), 32'({1'b1, 4'd0, 2'd0, 8'h41}));
    chk("first_cursor", 32'({cur_col, cur_row}), 32'({4'd1, 2'd0}));

    mv(8'h74, 15);
    mv(8'h72, 3);
    chk("sat_corner", 32'({wr_en, cur_col, cur_row}), 32'({1'b0, 4'd15, 2'd3}));
    send(1'b1, 8'h42, 1'b0, 8'h00, 1'b0);
    chk("wrap_write", 32'({wr_en, wr_col, wr_row, wr_char}), 32'({1'b1, 4'd15, 2'd3, 8'h42}));
    chk("wrap_cursor", 32'({cur_col, cur_row}), 0);

    mv(8'h72, 2);
    send(1'b1, 8'h08, 1'b0, 8'h00, 1'b0);
    chk("bs_write", 32'({wr_en, wr_col, wr_row, wr_char}), 32'({1'b1, 4'd15, 2'd1, 8'h20}));
    chk("bs_cursor", 32'({cur_col, cur_row}), 32'({4'd15, 2'd1}));

    mv(8'h75, 5);
    mv(8'h6B, 20);
    chk("sat_home", 32'({cur_col, cur_row}), 0);
    send(1'b1, 8'h08, 1'b0, 8'h00, 1'b0);
    chk("bs_home", 32'({wr_en, cur_col, cur_row}), 0);
    send(1'b0, 8'h00, 1'b1, 8'h6B, 1'b0);
    chk("left_home", 32'({wr_en, cur_col, cur_row}), 0);
    send(1'b0, 8'h00, 1'b1, 8'h75, 1'b0);
    chk("up_home", 32'({wr_en, cur_col, cur_row}), 0);

    send(1'b1, 8'h43, 1'b1, 8'h74, 1'b0);
    chk("both_write", 32'({wr_en, wr_col, wr_row, wr_char}), 32'({1'b1, 4'd0, 2'd0, 8'h43}));
    chk("both_cursor", 32'({cur_col, cur_row}), 32'({4'd1, 2'd0}));

    send(1'b1, 8'h0D, 1'b0, 8'h00, 1'b0);
    chk("cr", 32'({wr_en, cur_col, cur_row}), 32'({1'b0, 4'd0, 2'd1}));
    mv(8'h72, 3);
    send(1'b1, 8'h0D, 1'b0, 8'h00, 1'b0);
    chk("cr_wrap", 32'({wr_en, cur_col, cur_row}), 0);
    send(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0);
    send(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0);

`ifdef TERM_INPUT_CTRL_CLEAR_EN
    send(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    cnt = 0;
    sweep_ok = 1'b1;
    while (busy && cnt < 200) begin
      if (!(wr_en && wr_col == CW'(cnt % COLS) && wr_row == RW'(cnt / COLS) && wr_char == 8'h20))
        sweep_ok = 1'b0;
      if (cnt == 5) begin ascii_vld = 1'b1; ascii = 8'h58; end
      else ascii_vld = 1'b0;
      cnt++;
      @(negedge clk);
    end
    ascii_vld = 1'b0;
    chk("clr_busy_cycles", 32'(cnt), 64);
    chk("clr_order", 32'(sweep_ok), 1);
    chk("clr_after", 32'({wr_en, cur_col, cur_row}), 0);

    send(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_now", 32'({wr_en, busy}), 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (wr_en || busy) cnt++;
      @(negedge clk);
    end
    chk("abort_quiet", 32'(cnt), 0);
    send(1'b1, 8'h51, 1'b0, 8'h00, 1'b0);
    chk("abort_idle", 32'({wr_en, wr_col, wr_row, wr_char}), 32'({1'b1, 4'd0, 2'd0, 8'h51}));
`else
    send(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (wr_en || busy) cnt++;
      @(negedge clk);
    end
    chk("noclr_quiet", 32'(cnt), 0);
    chk("noclr_cursor", 32'({cur_col, cur_row}), 32'({4'd2, 2'd0}));
    send(1'b1, 8'h1B, 1'b0, 8'h00, 1'b0);
    chk("noclr_esc", 32'({wr_en, busy, cur_col, cur_row}), 32'({1'b0, 1'b0, 4'd2, 2'd0}));
`endif

    for (int i = 0; i < 4000; i++) begin
      ascii_vld = ($urandom % 3) == 0;
      case ($urandom % 8)
        0:       ascii = 8'h0D;
        1:       ascii = 8'h08;
        2:       ascii = (($urandom % 20) == 0) ? 8'h1B : 8'($urandom);
        default: ascii = 8'($urandom_range(32'h20, 32'h7E));
      endcase
      scan_vld = ($urandom % 3) == 0;
      case ($urandom % 5)
        0:       scan = 8'h6B;
        1:       scan = 8'h74;
        2:       scan = 8'h75;
        3:       scan = 8'h72;
        default: scan = 8'($urandom);
      endcase
      clear_req = ($urandom % 400) == 0;
      @(negedge clk);
    end
    ascii_vld = 1'b0; scan_vld = 1'b0; clear_req = 1'b0;
    repeat (80) @(negedge clk);
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/term_input_ctrl.md
TERM_INPUT_CTRL -- requirements
Module: term_input_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 80, number of text columns (2..256).
REQ-002 SHALL have parameter ROWS, default 25, number of text rows (2..256).
REQ-003 SHALL derive localparams COL_W = $clog2(COLS) and ROW_W = $clog2(ROWS).
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have ports ascii_vld (input, 1) and ascii (input, 8): one-cycle ASCII key strobe and its code.
REQ-007 SHALL have ports scan_vld (input, 1) and scan (input, 8): one-cycle scancode strobe and its code.
REQ-008 SHALL have port clear_req, input, 1, level request to clear the screen.
REQ-009 SHALL have ports wr_en (output, 1), wr_col (output, COL_W), wr_row (output, ROW_W) and wr_char (output, 8): character-buffer write port.
REQ-010 SHALL have ports cur_col (output, COL_W) and cur_row (output, ROW_W): cursor position.
REQ-011 SHALL have port busy, output, 1, high while a clear is in progress.

Function
REQ-012 Every output SHALL be registered; a write SHALL appear on wr_* exactly 1 cycle after the accepted strobe, and cursor outputs SHALL update in that same cycle.
REQ-013 Printable ASCII (0x20-0x7E) SHALL write the code at the cursor, then advance col; at col COLS-1, col SHALL become 0 and row SHALL become row+1.
REQ-014 Row SHALL wrap from ROWS-1 to 0 on any downward advance (printable, Enter).
REQ-015 Enter (0x0D) SHALL set col 0 and advance row without a write.
REQ-016 Backspace (0x08) SHALL move the cursor back one cell (col 0 -> col COLS-1 of row-1) and write 0x20 at the new position; at (0,0) it SHALL do nothing.
REQ-017 Other non-printable ASCII codes SHALL be ignored.
REQ-018 Scancodes 0x6B/0x74/0x75/0x72 SHALL move the cursor left/right/up/down by one cell, saturating at the screen edges, without a write; other scancodes SHALL be ignored.
REQ-019 When ascii_vld and scan_vld are high in the same cycle, the ASCII event SHALL be processed and the scancode dropped.
REQ-020 FSM states SHALL be IDLE and CLEAR; IDLE -> CLEAR on clear_req (or ESC 0x1B when enabled); CLEAR -> IDLE after the last cell write.
REQ-021 CLEAR SHALL write 0x20 to every cell, one per cycle, row-major from (0,0) to (COLS-1,ROWS-1), with busy high for exactly COLS*ROWS cycles, then home the cursor to (0,0).
REQ-022 All ascii, scan and clear_req events arriving while busy SHALL be dropped.

Reset
REQ-023 Reset SHALL force state IDLE, cursor (0,0), wr_en 0, wr_col/wr_row/wr_char 0 and busy 0.
REQ-024 Reset asserted during CLEAR SHALL abort the sweep immediately with no further writes.

Configuration
REQ-025 Macro TERM_INPUT_CTRL_CLEAR_EN SHALL, when defined, compile in the CLEAR state, the clear_req port function and ESC handling.
REQ-026 Without the macro, clear_req and ESC SHALL be ignored, busy SHALL be tied 0 and no sweep counter SHALL be synthesised.

Structure
REQ-027 Package term_pkg SHALL hold the ASCII constants (CR, BS, ESC, SPACE), the scancode constants (LEFT, RIGHT, UP, DOWN) and the state enum type.
REQ-028 Next-cursor arithmetic SHALL live in a combinational sub-module term_cursor_step (inputs: position and event; outputs: next position and write flag).

Verification (COLS=16, ROWS=4)
REQ-029 Reset, then ascii 0x41 -> next cycle wr_en=1, (0,0), 'A'; cursor (1,0).
REQ-030 Cursor at (15,3), ascii 0x42 -> write at (15,3); cursor (0,0).
REQ-031 Cursor at (0,2), ascii 0x08 -> write 0x20 at (15,1); cursor (15,1). At (0,0), ascii 0x08 -> no write; cursor stays (0,0).
REQ-032 Cursor at (0,0), scan 0x6B then 0x75 -> cursor stays (0,0) with no writes; ascii and scan in the same cycle -> only the ASCII event takes effect.
REQ-033 CLEAR_EN defined, clear_req pulse -> busy high for 64 cycles, 64 space writes in row-major order, cursor (0,0); an ascii event during busy is dropped.
REQ-034 Reset asserted at sweep cycle 10 -> wr_en low from then on and state IDLE; without CLEAR_EN, clear_req -> no writes and busy=0.
